bp_be_cache_req_arbiter: RTL and testbench
==========================================

# bp_be_cache_req_arbiter

Two-requester arbiter between backend D$ miss sources and the single LCE-facing cache request port. The two sources are the primary D$ miss path and a secondary source such as the uncached/PTW path. Grants the port to one owner at a time and forwards that owner's request and trailing metadata. Routes the LCE's critical/complete strobes back to the owner only, and holds ownership until the transaction completes. Round-robin priority prevents starvation.

## Interface
Parameters:
- req_width_p, default 64: width of one cache request packet.
- metadata_width_p, default 8: width of one request metadata packet.

Ports:
- clk_i, in, 1: clock.
- reset_n_i, in, 1: reset, synchronous, active-low.
- reqN_i, in, req_width_p (N=0,1): request packet from requester N.
- reqN_v_i, in, 1: request N valid.
- reqN_ready_o, out, 1: request N accepted when reqN_v_i & reqN_ready_o.
- reqN_metadata_i, in, metadata_width_p: metadata from requester N.
- reqN_metadata_v_i, in, 1: metadata N valid.
- reqN_critical_o, out, 1: critical strobe routed to requester N.
- reqN_complete_o, out, 1: complete strobe routed to requester N.
- cache_req_o, out, req_width_p: request to LCE.
- cache_req_v_o, out, 1: request valid to LCE.
- cache_req_ready_i, in, 1: LCE ready.
- cache_req_metadata_o, out, metadata_width_p: metadata to LCE.
- cache_req_metadata_v_o, out, 1: metadata valid to LCE.
- cache_req_critical_i, in, 1: LCE critical strobe.
- cache_req_complete_i, in, 1: LCE complete strobe.
- busy_o, out, 1: a transaction is outstanding (state ≠ IDLE).
- owner_o, out, 1: current or most recent owner id.

## Operation
- FSM states: IDLE, META, BUSY. Registers: state, owner, prio (requester with priority), meta_seen.
- IDLE, arbitration:
  - sel = the only valid requester.
  - If both are valid, sel = prio.
  - If neither is valid, sel = prio and cache_req_v_o = 0.
- IDLE, outputs:
  - cache_req_o = req_sel_i.
  - cache_req_v_o = req_sel_v_i.
  - reqsel_ready_o = cache_req_ready_i.
  - The other ready is 0.
  - Ready never depends on the other requester's request contents.
- IDLE, on handshake (req_sel_v_i & cache_req_ready_i):
  - owner <= sel.
  - prio <= ~sel.
  - state -> META.
- META:
  - All reqN_ready_o = 0; cache_req_v_o = 0.
  - cache_req_metadata_o/_v_o forward the owner's metadata combinationally.
  - On owner metadata_v -> BUSY.
  - Metadata from the non-owner is never forwarded.
- BUSY: no new requests accepted. Metadata valid is 0.
- META/BUSY strobes:
  - cache_req_critical_i is routed to reqowner_critical_o only.
  - cache_req_complete_i is routed to reqowner_complete_o only.
  - The non-owner's strobes are 0.
- Complete, either state:
  - cache_req_complete_i -> IDLE.
  - This includes complete in META with no metadata yet (uncached-style flows).
  - Any later owner metadata is dropped.
- Complete and metadata_v in the same cycle in META: the metadata is forwarded, then -> IDLE.
- Strobes received in IDLE are discarded; no req*_critical_o/complete_o pulses.
- Single-requester traffic never waits on prio.

## Timing
- Request path is zero latency (combinational valid->valid and ready->ready). Grant decision uses only registered prio plus current valids.
- Metadata path is zero latency, forwarded in the same cycle.
- Critical/complete path is zero latency.
- Back-to-back: the earliest next request handshake is the cycle after cache_req_complete_i, because the FSM is in IDLE that cycle.
- Reset (reset_n_i=0 at a clock edge), including mid-transaction:
  - state=IDLE, owner=0, prio=0.
  - All outputs 0 during reset: *_ready_o, cache_req_v_o, metadata_v, strobes, busy_o, owner_o.
  - No strobe is delivered for an aborted transaction.
- reqN_v_i may drop before ready without penalty; no lock-in in IDLE.

## Test plan
- After reset, req0_v=1, req1_v=1, ready=1:
  - Cycle 0: req0 granted (req0_ready_o=1, req1_ready_o=0, owner_o=0).
  - req0_metadata_v one cycle later -> cache_req_metadata_v_o=1; busy_o=1.
  - complete_i pulse -> req0_complete_o=1, req1_complete_o=0.
  - Next cycle: req1 granted.
- Both valid continuously, 4 transactions: grant order 0,1,0,1. Each grant occurs the cycle after complete.
- Only req1 valid, prio=0: req1 granted immediately; prio then = 0.
- Owner req1 in META:
  - req0_metadata_v_i=1 -> cache_req_metadata_v_o=0.
  - req1_metadata_v_i=1 -> forwarded with req1 payload.
- Complete in META with no metadata -> IDLE. A subsequent stray owner metadata_v is not forwarded.
- reset_n_i=0 in BUSY with critical_i=1 that cycle:
  - All outputs 0.
  - Post-reset: IDLE, req0 wins a tie.

Source files
------------

// File: rtl/bp_be_cache_req_arbiter.sv
// Two-requester arbiter for the single LCE cache request port. The port is granted
// round-robin, held through metadata and completion, and strobes go to the owner only.
module bp_be_cache_req_arbiter #(
  parameter int req_width_p      = 64,
  parameter int metadata_width_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic [req_width_p-1:0]      req0_i,
  input  logic                        req0_v_i,
  output logic                        req0_ready_o,
  input  logic [metadata_width_p-1:0] req0_metadata_i,
  input  logic                        req0_metadata_v_i,
  output logic                        req0_critical_o,
  output logic                        req0_complete_o,

  input  logic [req_width_p-1:0]      req1_i,
  input  logic                        req1_v_i,
  output logic                        req1_ready_o,
  input  logic [metadata_width_p-1:0] req1_metadata_i,
  input  logic                        req1_metadata_v_i,
  output logic                        req1_critical_o,
  output logic                        req1_complete_o,

  output logic [req_width_p-1:0]      cache_req_o,
  output logic                        cache_req_v_o,
  input  logic                        cache_req_ready_i,
  output logic [metadata_width_p-1:0] cache_req_metadata_o,
  output logic                        cache_req_metadata_v_o,
  input  logic                        cache_req_critical_i,
  input  logic                        cache_req_complete_i,

  output logic                        busy_o,
  output logic                        owner_o
);

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_meta = 2'd1,
    e_busy = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   prio_q, prio_d;
  logic   meta_seen_q, meta_seen_d;

  logic   sel_s;
  logic   sel_v_s;
  logic   own_meta_v_s;

  // Grant selection: a lone requester wins outright, ties go to the priority holder.
  always_comb begin
    sel_s = prio_q;
    if (req0_v_i && !req1_v_i) begin
      sel_s = 1'b0;
    end else if (req1_v_i && !req0_v_i) begin
      sel_s = 1'b1;
    end else begin
      sel_s = prio_q;
    end
    sel_v_s      = sel_s ? req1_v_i : req0_v_i;
    own_meta_v_s = owner_q ? req1_metadata_v_i : req0_metadata_v_i;
  end

  // Next-state logic; complete always returns to IDLE, even before metadata arrives.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    meta_seen_d = meta_seen_q;
    case (state_q)
      e_idle: begin
        meta_seen_d = 1'b0;
        if (sel_v_s && cache_req_ready_i) begin
          owner_d = sel_s;
          prio_d  = ~sel_s;
          state_d = e_meta;
        end else begin
          state_d = e_idle;
        end
      end
      e_meta: begin
        if (cache_req_complete_i) begin
          state_d = e_idle;
        end else if (own_meta_v_s) begin
          meta_seen_d = 1'b1;
          state_d     = e_busy;
        end else begin
          state_d = e_meta;
        end
      end
      e_busy: begin
        if (cache_req_complete_i) begin
          state_d = e_idle;
        end else begin
          state_d = e_busy;
        end
      end
      default: begin
        state_d = e_idle;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= e_idle;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      meta_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      meta_seen_q <= meta_seen_d;
    end
  end

  // Output routing; everything is held at zero while reset is asserted so an
  // aborted transaction never sees a strobe.
  always_comb begin
    req0_ready_o           = 1'b0;
    req1_ready_o           = 1'b0;
    req0_critical_o        = 1'b0;
    req1_critical_o        = 1'b0;
    req0_complete_o        = 1'b0;
    req1_complete_o        = 1'b0;
    cache_req_o            = '0;
    cache_req_v_o          = 1'b0;
    cache_req_metadata_o   = '0;
    cache_req_metadata_v_o = 1'b0;
    busy_o                 = 1'b0;
    owner_o                = 1'b0;
    if (reset_n_i) begin
      owner_o = owner_q;
      busy_o  = (state_q != e_idle);
      case (state_q)
        e_idle: begin
          cache_req_o   = sel_s ? req1_i : req0_i;
          cache_req_v_o = sel_v_s;
          if (sel_s) begin
            req1_ready_o = cache_req_ready_i;
          end else begin
            req0_ready_o = cache_req_ready_i;
          end
        end
        e_meta, e_busy: begin
          if (state_q == e_meta) begin
            cache_req_metadata_o   = owner_q ? req1_metadata_i : req0_metadata_i;
            cache_req_metadata_v_o = own_meta_v_s && !meta_seen_q;
          end else begin
            cache_req_metadata_v_o = 1'b0;
          end
          if (owner_q) begin
            req1_critical_o = cache_req_critical_i;
            req1_complete_o = cache_req_complete_i;
          end else begin
            req0_critical_o = cache_req_critical_i;
            req0_complete_o = cache_req_complete_i;
          end
        end
        default: begin
          busy_o = 1'b0;
        end
      endcase
    end else begin
      owner_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_bp_be_cache_req_arbiter.sv
// Self-checking bench: directed scenarios followed by randomized traffic, compared
// against a transaction-level reference model.
module tb_bp_be_cache_req_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] req [2];
  logic [1:0]  v;
  logic [7:0]  meta [2];
  logic [1:0]  meta_v;
  logic        ready_i, crit_i, comp_i;

  logic        req0_ready_o, req1_ready_o;
  logic        req0_critical_o, req1_critical_o, req0_complete_o, req1_complete_o;
  logic [63:0] cache_req_o;
  logic        cache_req_v_o;
  logic [7:0]  cache_req_metadata_o;
  logic        cache_req_metadata_v_o, busy_o, owner_o;

  int checks = 0;
  int errors = 0;

  // Reference model: is a transaction in flight, who owns it, has its metadata gone out.
  bit m_inflight, m_owner, m_prio, m_meta_done;

  always #5 clk = ~clk;

  bp_be_cache_req_arbiter #(.req_width_p(64), .metadata_width_p(8)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req0_i(req[0]), .req0_v_i(v[0]), .req0_ready_o(req0_ready_o),
    .req0_metadata_i(meta[0]), .req0_metadata_v_i(meta_v[0]),
    .req0_critical_o(req0_critical_o), .req0_complete_o(req0_complete_o),
    .req1_i(req[1]), .req1_v_i(v[1]), .req1_ready_o(req1_ready_o),
    .req1_metadata_i(meta[1]), .req1_metadata_v_i(meta_v[1]),
    .req1_critical_o(req1_critical_o), .req1_complete_o(req1_complete_o),
    .cache_req_o(cache_req_o), .cache_req_v_o(cache_req_v_o),
    .cache_req_ready_i(ready_i),
    .cache_req_metadata_o(cache_req_metadata_o),
    .cache_req_metadata_v_o(cache_req_metadata_v_o),
    .cache_req_critical_i(crit_i), .cache_req_complete_i(comp_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit winner();
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    return m_prio;
  endfunction

  // Compare every output with the model, then advance one clock and update the model.
  task automatic tick(input string tag);
    bit w;
    logic [1:0] rdy, crit, comp;
    #1;
    w = winner();
    rdy = 2'b00; crit = 2'b00; comp = 2'b00;
    if (!reset_n) begin
      chk({tag, ":rdy"}, {req1_ready_o, req0_ready_o}, 2'b00);
      chk({tag, ":v"}, cache_req_v_o, 1'b0);
      chk({tag, ":mv"}, cache_req_metadata_v_o, 1'b0);
      chk({tag, ":strb"}, {req1_critical_o, req0_critical_o, req1_complete_o, req0_complete_o}, 4'b0);
      chk({tag, ":busy"}, busy_o, 1'b0);
      chk({tag, ":own"}, owner_o, 1'b0);
    end else if (!m_inflight) begin
      rdy[w] = ready_i;
      chk({tag, ":rdy"}, {req1_ready_o, req0_ready_o}, rdy);
      chk({tag, ":v"}, cache_req_v_o, v[w]);
      if (v[w]) chk({tag, ":req"}, cache_req_o, req[w]);
      chk({tag, ":mv"}, cache_req_metadata_v_o, 1'b0);
      chk({tag, ":strb"}, {req1_critical_o, req0_critical_o, req1_complete_o, req0_complete_o}, 4'b0);
      chk({tag, ":busy"}, busy_o, 1'b0);
      chk({tag, ":own"}, owner_o, m_owner);
    end else begin
      crit[m_owner] = crit_i;
      comp[m_owner] = comp_i;
      chk({tag, ":rdy"}, {req1_ready_o, req0_ready_o}, 2'b00);
      chk({tag, ":v"}, cache_req_v_o, 1'b0);
      chk({tag, ":mv"}, cache_req_metadata_v_o, !m_meta_done && meta_v[m_owner]);
      if (!m_meta_done && meta_v[m_owner]) chk({tag, ":md"}, cache_req_metadata_o, meta[m_owner]);
      chk({tag, ":crit"}, {req1_critical_o, req0_critical_o}, crit);
      chk({tag, ":comp"}, {req1_complete_o, req0_complete_o}, comp);
      chk({tag, ":busy"}, busy_o, 1'b1);
      chk({tag, ":own"}, owner_o, m_owner);
    end
    @(posedge clk);
    if (!reset_n) begin
      m_inflight = 1'b0; m_owner = 1'b0; m_prio = 1'b0; m_meta_done = 1'b0;
    end else if (!m_inflight) begin
      if (v[w] && ready_i) begin
        m_inflight = 1'b1; m_owner = w; m_prio = !w; m_meta_done = 1'b0;
      end
    end else if (comp_i) begin
      m_inflight = 1'b0;
    end else if (!m_meta_done && meta_v[m_owner]) begin
      m_meta_done = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    v = 2'b00; meta_v = 2'b00; ready_i = 1'b0; crit_i = 1'b0; comp_i = 1'b0;
  endtask

  initial begin
    bit exp_order [4];
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    m_inflight = 1'b0; m_owner = 1'b0; m_prio = 1'b0; m_meta_done = 1'b0;
    req[0] = 64'h0000_0000_AAAA_0000; req[1] = 64'h0000_0000_BBBB_1111;
    meta[0] = 8'h5A; meta[1] = 8'hC3;
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    v = 2'b11; ready_i = 1'b1;
    tick("rst0");
    tick("rst1");

    // Tie after reset goes to requester 0, then metadata, complete, then requester 1.
    reset_n = 1'b1;
    #1 chk("tie_r0", {req1_ready_o, req0_ready_o}, 2'b01);
    tick("grant0");
    meta_v = 2'b01;
    #1 chk("meta0_fwd", {busy_o, cache_req_metadata_v_o}, 2'b11);
    tick("meta0");
    meta_v = 2'b00; comp_i = 1'b1;
    #1 chk("comp0", {req1_complete_o, req0_complete_o}, 2'b01);
    tick("comp0");
    comp_i = 1'b0;
    #1 chk("next_r1", {req1_ready_o, req0_ready_o}, 2'b10);
    tick("grant1");
    meta_v = 2'b01;
    #1 chk("nonowner_meta", cache_req_metadata_v_o, 1'b0);
    tick("meta_no");
    meta_v = 2'b10;
    #1 chk("owner_meta", {cache_req_metadata_v_o, cache_req_metadata_o}, {1'b1, 8'hC3});
    tick("meta1");
    meta_v = 2'b00; comp_i = 1'b1;
    tick("comp1");
    comp_i = 1'b0;

    // Four back-to-back transactions with both requesters always valid.
    for (int t = 0; t < 4; t++) begin
      #1 chk("rr_order", owner_o ^ owner_o ^ req1_ready_o, exp_order[t]);
      tick("rr_grant");
      meta_v[exp_order[t]] = 1'b1;
      tick("rr_meta");
      meta_v = 2'b00; comp_i = 1'b1;
      tick("rr_comp");
      comp_i = 1'b0;
    end

    // Lone requester 1 while priority sits with requester 0; complete without metadata.
    v = 2'b10;
    #1 chk("lone_r1", req1_ready_o, 1'b1);
    tick("lone_grant");
    v = 2'b00; comp_i = 1'b1;
    tick("meta_less_comp");
    comp_i = 1'b0; meta_v = 2'b10;
    #1 chk("stray_meta", cache_req_metadata_v_o, 1'b0);
    tick("stray");
    meta_v = 2'b00;
    v = 2'b11;
    #1 chk("prio_kept0", req0_ready_o, 1'b1);
    tick("grant_pre_rst");
    meta_v = 2'b01;
    tick("meta_pre_rst");

    // Reset in BUSY while a critical strobe arrives.
    meta_v = 2'b00; crit_i = 1'b1; reset_n = 1'b0;
    #1 chk("rst_crit", {req1_critical_o, req0_critical_o, busy_o}, 3'b000);
    tick("rst_busy");
    crit_i = 1'b0; reset_n = 1'b1;
    #1 chk("post_rst_tie", {req1_ready_o, req0_ready_o}, 2'b01);
    tick("post_rst");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      v       = 2'($urandom_range(0, 3));
      ready_i = ($urandom_range(0, 3) != 0);
      meta_v  = 2'($urandom_range(0, 3));
      crit_i  = 1'($urandom_range(0, 1));
      comp_i  = ($urandom_range(0, 3) == 0);
      req[0]  = {$urandom, $urandom};
      req[1]  = {$urandom, $urandom};
      meta[0] = 8'($urandom);
      meta[1] = 8'($urandom);
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
